wb_router_rf_mem: RTL and testbench
===================================

// Module: wb_router_rf_mem
// PURPOSE
//  Writeback router: the output-side counterpart of the rf/mem/imm operand mux. Takes one
//  result from the execute stage and delivers it to the register file, to data memory, or to
//  both, per a 2-bit destination select. RF write takes one cycle. The memory write uses a
//  req/ack handshake with a timeout. A one-entry capture register frees the upstream stage.
// PARAMETERS
//  DATA_WIDTH       8   result / write-data width
//  MEM_ADDR_WIDTH   8   data-memory address width
//  RF_ADDR_WIDTH    3   register-file index width
//  DEST_SELECT_BITS 2   destination select width
//  MEM_TIMEOUT      15  max cycles in MEM_REQ without ack before abort (>=1)
// PORTS
//  clk            in   1                 single clock, rising edge
//  rst_n          in   1                 asynchronous, active-low reset
//  in_valid       in   1                 upstream result valid
//  in_ready       out  1                 router can accept (1 only in IDLE)
//  in_data        in   DATA_WIDTH        result to write back
//  in_dest        in   DEST_SELECT_BITS  00=RF, 01=MEM, 10=BOTH, 11=DISCARD
//  in_rf_addr     in   RF_ADDR_WIDTH     RF destination index
//  in_mem_addr    in   MEM_ADDR_WIDTH    memory destination address
//  rf_we          out  1                 RF write strobe, one cycle
//  rf_waddr       out  RF_ADDR_WIDTH     RF write index (captured)
//  rf_wdata       out  DATA_WIDTH        RF write data (captured)
//  mem_req        out  1                 memory write request, level, held until ack/timeout
//  mem_addr       out  MEM_ADDR_WIDTH    memory address (captured, stable while mem_req)
//  mem_wdata      out  DATA_WIDTH        memory write data (captured, stable while mem_req)
//  mem_ack        in   1                 memory accepted write; sampled only while mem_req=1
//  done           out  1                 one-cycle pulse: transaction finished (incl. abort)
//  err_timeout    out  1                 sticky: a memory write was aborted
//  err_clear      in   1                 synchronous clear of err_timeout
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; rf_we, mem_req, done, err_timeout=0.
//    Capture regs and timeout counter=0. in_ready=1 (decoded from IDLE).
//  - States: IDLE, RF_WR, MEM_REQ. Accept = in_valid & in_ready; on accept, latch data,
//    dest, and both addrs. Inputs are ignored outside IDLE.
//  - IDLE->RF_WR on accept with dest 00/10. IDLE->MEM_REQ on dest 01. dest 11: stay IDLE,
//    pulse done next cycle, no writes.
//  - RF_WR: rf_we=1 for exactly this cycle (1 cycle after accept). dest 00 -> IDLE with
//    done=1 in the same cycle. dest 10 -> MEM_REQ, done not yet.
//  - MEM_REQ: mem_req=1, mem_addr/mem_wdata constant. mem_ack=1 sampled -> IDLE, done=1
//    that cycle. An ack in the first MEM_REQ cycle counts.
//  - Timeout: counter clears on MEM_REQ entry and increments each MEM_REQ cycle without ack.
//    If MEM_TIMEOUT cycles pass with no ack: drop mem_req, go IDLE, done=1, set err_timeout.
//    Ack on the final cycle wins over timeout (no error).
//  - err_timeout holds until err_clear=1 or reset. A set and a clear in the same cycle give set.
//  - mem_ack while mem_req=0 is ignored. Back-to-back: in_ready returns on the first IDLE
//    cycle, so min throughput is 1 txn / 2 cycles (RF) and / 2+N cycles (MEM).
//  - Reset mid-transaction aborts immediately: mem_req, rf_we=0. No done, no error.
// STRUCTURE
//  - Shared package wb_pkg: typedef enum wb_dest_e {WB_RF, WB_MEM, WB_BOTH, WB_DISCARD}.
//    Also typedef enum wb_state_e {IDLE, RF_WR, MEM_REQ}. Widths come from DEST_SELECT_BITS.
//  - Sub-module: wb_timeout_counter (clear, enable, parameter LIMIT -> expired). All other
//    logic is inline FSM + capture regs.
// TESTING
//  - RF only: accept data=8'hA5, dest=00, rf_addr=3. Next cycle rf_we=1, waddr=3, wdata=A5,
//    done=1. Then in_ready=1.
//  - MEM, ack after 3 cycles: data=8'h3C, addr=8'h80. mem_req held 3 cycles with stable
//    addr/data. Drop on ack, done=1, err_timeout=0.
//  - BOTH: dest=10, data=8'h11, ack immediately. rf_we cycle 1, mem_req cycle 2, done cycle 2.
//  - Timeout: dest=01, no ack. mem_req high 15 cycles, then 0, done=1, err_timeout=1.
//    err_clear -> err_timeout=0.
//  - Ack on cycle 15 exactly: no error. Stray mem_ack in IDLE: no effect.
//  - rst_n low during MEM_REQ: mem_req=0 async, no done. in_valid during RF_WR is not accepted.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback router: destination select encoding and FSM states.
package wb_pkg;

  localparam int DEST_SELECT_BITS = 2;

  typedef enum logic [DEST_SELECT_BITS-1:0] {
    WB_RF      = 2'b00,
    WB_MEM     = 2'b01,
    WB_BOTH    = 2'b10,
    WB_DISCARD = 2'b11
  } wb_dest_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RF_WR   = 2'b01,
    MEM_REQ = 2'b10
  } wb_state_e;

  function automatic logic dest_has_rf(input wb_dest_e dest);
    return (dest == WB_RF) || (dest == WB_BOTH);
  endfunction

endpackage

// File: rtl/wb_router_rf_mem_if.sv
// Bus bundle for the writeback router: upstream result, RF write port, memory handshake, status.
interface wb_router_rf_mem_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int RF_ADDR_WIDTH  = 3
);

  logic                                 in_valid;
  logic                                 in_ready;
  logic [DATA_WIDTH-1:0]                in_data;
  logic [wb_pkg::DEST_SELECT_BITS-1:0]  in_dest;
  logic [RF_ADDR_WIDTH-1:0]             in_rf_addr;
  logic [MEM_ADDR_WIDTH-1:0]            in_mem_addr;

  logic                                 rf_we;
  logic [RF_ADDR_WIDTH-1:0]             rf_waddr;
  logic [DATA_WIDTH-1:0]                rf_wdata;

  logic                                 mem_req;
  logic [MEM_ADDR_WIDTH-1:0]            mem_addr;
  logic [DATA_WIDTH-1:0]                mem_wdata;
  logic                                 mem_ack;

  logic                                 done;
  logic                                 err_timeout;
  logic                                 err_clear;

  // Router side.
  modport slave (
    input  in_valid, in_data, in_dest, in_rf_addr, in_mem_addr, mem_ack, err_clear,
    output in_ready, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata,
           done, err_timeout
  );

  // Execute stage / memory / control side.
  modport master (
    output in_valid, in_data, in_dest, in_rf_addr, in_mem_addr, mem_ack, err_clear,
    input  in_ready, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata,
           done, err_timeout
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Counts cycles spent waiting for a memory ack; expired marks the LIMIT-th waiting cycle.
module wb_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // count holds the number of completed waiting cycles, so the current cycle is count+1.
  assign expired = (count == CW'(LIMIT - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register sees pre-edge values of the others and simulation matches the netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_router_rf_mem.sv
// Writeback router: captures one execute result and writes it to the RF, data memory, or both.
module wb_router_rf_mem
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int RF_ADDR_WIDTH  = 3,
  parameter int MEM_TIMEOUT    = 15
) (
  input logic               clk,
  input logic               rst_n,
  wb_router_rf_mem_if.slave bus
);

  wb_state_e                 state;
  wb_dest_e                  dest_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [RF_ADDR_WIDTH-1:0]  rf_addr_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic                      rf_we_q;
  logic                      mem_req_q;
  logic                      discard_q;
  logic                      err_q;

  wb_dest_e in_dest_e;
  logic     accept;
  logic     in_mem_req;
  logic     tmo_expired;
  logic     mem_abort;

  assign in_dest_e  = wb_dest_e'(bus.in_dest);
  assign accept     = bus.in_valid && (state == IDLE);
  assign in_mem_req = (state == MEM_REQ);
  assign mem_abort  = in_mem_req && tmo_expired && !bus.mem_ack;

  wb_timeout_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_mem_req),
    .enable  (in_mem_req && !bus.mem_ack),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dest_q     <= WB_RF;
      data_q     <= '0;
      rf_addr_q  <= '0;
      mem_addr_q <= '0;
      rf_we_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      discard_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      discard_q <= 1'b0;

      // NOTE: the set is written after the clear so a same-cycle abort wins.
      if (bus.err_clear) err_q <= 1'b0;
      if (mem_abort)     err_q <= 1'b1;

      unique case (state)
        IDLE: begin
          if (accept) begin
            data_q     <= bus.in_data;
            dest_q     <= in_dest_e;
            rf_addr_q  <= bus.in_rf_addr;
            mem_addr_q <= bus.in_mem_addr;
            if (dest_has_rf(in_dest_e)) begin
              state   <= RF_WR;
              rf_we_q <= 1'b1;
            end else if (in_dest_e == WB_MEM) begin
              state     <= MEM_REQ;
              mem_req_q <= 1'b1;
            end else begin
              discard_q <= 1'b1;
            end
          end
        end

        RF_WR: begin
          rf_we_q <= 1'b0;
          if (dest_q == WB_BOTH) begin
            state     <= MEM_REQ;
            mem_req_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        MEM_REQ: begin
          // Ack on the final timeout cycle still counts as a clean completion.
          if (bus.mem_ack || tmo_expired) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          rf_we_q   <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // done is decoded so an RF-only write and a memory completion both report in their final cycle.
  assign bus.done = discard_q
                 || ((state == RF_WR) && (dest_q == WB_RF))
                 || (in_mem_req && (bus.mem_ack || tmo_expired));

  assign bus.in_ready    = (state == IDLE);
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_addr_q;
  assign bus.rf_wdata    = data_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = data_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_wb_router_rf_mem.sv
// Scoreboard bench for wb_router_rf_mem: directed transactions, a memory responder and a done-driven monitor.
module tb_wb_router_rf_mem;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_router_rf_mem_if bus ();

  wb_router_rf_mem dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rf;
    logic [2:0] rf_addr;
    logic [7:0] rf_data;
    int         mem_cycles;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       abort;
  } exp_t;

  exp_t sb[$];

  // Memory responder: raises mem_ack during the ack_at-th mem_req cycle (0 = never).
  int   ack_at = 0;
  logic stray_ack = 1'b0;
  int   req_cnt = 0;

  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) req_cnt++;
      else             req_cnt = 0;
      bus.mem_ack = stray_ack || (bus.mem_req && (ack_at != 0) && (req_cnt == ack_at));
    end
  end

  // Monitor: accumulates writes seen since the last done, compares on each done pulse.
  logic       o_rf = 1'b0;
  logic [2:0] o_rfa = '0;
  logic [7:0] o_rfd = '0;
  int         o_cyc = 0;
  logic [7:0] o_ma = '0;
  logic [7:0] o_md = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        o_rf  = 1'b0;
        o_cyc = 0;
      end else begin
        if (bus.rf_we) begin
          o_rf  = 1'b1;
          o_rfa = bus.rf_waddr;
          o_rfd = bus.rf_wdata;
        end
        if (bus.mem_req) begin
          if (o_cyc == 0) begin
            o_ma = bus.mem_addr;
            o_md = bus.mem_wdata;
          end else begin
            check("mem_addr_stable", bus.mem_addr, o_ma);
            check("mem_wdata_stable", bus.mem_wdata, o_md);
          end
          o_cyc++;
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_without_txn: got done=1, expected no done (scoreboard empty)");
          end else begin
            e = sb.pop_front();
            check("rf_written", o_rf, e.rf);
            if (e.rf) begin
              check("rf_waddr", o_rfa, e.rf_addr);
              check("rf_wdata", o_rfd, e.rf_data);
            end
            check("mem_req_cycles", o_cyc, e.mem_cycles);
            if (e.mem_cycles > 0) begin
              check("mem_addr", o_ma, e.mem_addr);
              check("mem_wdata", o_md, e.mem_data);
            end
            check("abort", bus.mem_req && !bus.mem_ack, e.abort);
          end
          o_rf  = 1'b0;
          o_cyc = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] dest, input logic [2:0] ra,
                      input logic [7:0] ma, input int ack, input int mem_cyc, input logic abort);
    exp_t e;
    ack_at       = ack;
    e.rf         = (dest == 2'b00) || (dest == 2'b10);
    e.rf_addr    = ra;
    e.rf_data    = d;
    e.mem_cycles = mem_cyc;
    e.mem_addr   = ma;
    e.mem_data   = d;
    e.abort      = abort;
    sb.push_back(e);
    @(posedge clk); #1;
    check("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.in_dest     = dest;
    bus.in_rf_addr  = ra;
    bus.in_mem_addr = ma;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got no done within 40 cycles, expected done pulse", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100us, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_dest     = '0;
    bus.in_rf_addr  = '0;
    bus.in_mem_addr = '0;
    bus.err_clear   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_rf_we", bus.rf_we, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err_timeout, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 8'h00);
    check("rst_rf_wdata", bus.rf_wdata, 8'h00);
    rst_n = 1'b1;

    // RF only.
    send(8'hA5, 2'b00, 3'd3, 8'h00, 0, 0, 1'b0);
    wait_done("rf_only");
    @(posedge clk); #1;
    check("rf_only_ready_after", bus.in_ready, 1'b1);

    // MEM, ack on the third request cycle.
    send(8'h3C, 2'b01, 3'd0, 8'h80, 3, 3, 1'b0);
    wait_done("mem_ack3");
    @(posedge clk); #1;
    check("mem_ack3_err", bus.err_timeout, 1'b0);
    check("mem_ack3_req_low", bus.mem_req, 1'b0);

    // BOTH, immediate ack.
    send(8'h11, 2'b10, 3'd6, 8'h22, 1, 1, 1'b0);
    wait_done("both");
    @(posedge clk); #1;
    check("both_err", bus.err_timeout, 1'b0);

    // Timeout with no ack.
    send(8'h5A, 2'b01, 3'd0, 8'h40, 0, 15, 1'b1);
    wait_done("timeout");
    @(posedge clk); #1;
    check("timeout_err_set", bus.err_timeout, 1'b1);
    check("timeout_req_low", bus.mem_req, 1'b0);
    bus.err_clear = 1'b1;
    @(posedge clk); #1;
    bus.err_clear = 1'b0;
    check("timeout_err_cleared", bus.err_timeout, 1'b0);

    // Ack on the final allowed cycle.
    send(8'hC3, 2'b01, 3'd0, 8'hFF, 15, 15, 1'b0);
    wait_done("ack_on_15");
    @(posedge clk); #1;
    check("ack_on_15_err", bus.err_timeout, 1'b0);

    // Stray ack while idle.
    stray_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stray_done", bus.done, 1'b0);
      check("stray_mem_req", bus.mem_req, 1'b0);
      check("stray_ready", bus.in_ready, 1'b1);
    end
    @(posedge clk); #1;
    stray_ack = 1'b0;

    // Discard.
    send(8'hEE, 2'b11, 3'd1, 8'h11, 0, 0, 1'b0);
    wait_done("discard");

    // in_valid held during RF_WR must not start a second transaction.
    begin
      exp_t e;
      e.rf = 1'b1; e.rf_addr = 3'd5; e.rf_data = 8'hA7;
      e.mem_cycles = 0; e.mem_addr = '0; e.mem_data = '0; e.abort = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'hA7;
    bus.in_dest    = 2'b00;
    bus.in_rf_addr = 3'd5;
    @(posedge clk); #1;
    check("rf_wr_not_ready", bus.in_ready, 1'b0);
    bus.in_data    = 8'h77;
    bus.in_rf_addr = 3'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rf_wr_single_txn", sb.size(), 0);

    // Set and clear in the same cycle: set wins.
    @(posedge clk); #1;
    bus.err_clear = 1'b1;
    send(8'h99, 2'b01, 3'd0, 8'h33, 0, 15, 1'b1);
    wait_done("set_vs_clear");
    @(posedge clk); #1;
    check("set_vs_clear_err", bus.err_timeout, 1'b1);
    @(posedge clk); #1;
    bus.err_clear = 1'b0;
    check("set_vs_clear_cleared", bus.err_timeout, 1'b0);

    // Reset during MEM_REQ.
    ack_at = 0;
    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.in_data     = 8'h42;
    bus.in_dest     = 2'b01;
    bus.in_mem_addr = 8'h10;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_mem_req", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_mem_req_async", bus.mem_req, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    check("reset_done_negedge", bus.done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset_err", bus.err_timeout, 1'b0);

    // Recovery after reset.
    send(8'h5C, 2'b00, 3'd7, 8'h00, 0, 0, 1'b0);
    wait_done("post_reset_rf");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
